// File: rtl/sobel_gradient_gen.sv
// 3x3 Sobel gradient generator: accumulates a raster-ordered window one pixel per
// accepted beat and presents signed gx/gy with a valid/ready handshake.
module sobel_gradient_gen (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic        clear,
    output logic [10:0] gx,
    output logic [10:0] gy,
    output logic        start_t_grad,
    input  logic        grad_ready
);

    typedef enum logic {LOAD, DONE} state_t;

    state_t             state, next_state;
    logic [3:0]         idx;
    logic signed [10:0] acc_x, acc_y;
    logic signed [10:0] pix, pix2;
    logic signed [10:0] dx, dy;
    logic signed [10:0] sum_x, sum_y;
    logic               take;
    logic               last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= LOAD;
        else        state <= next_state;
    end

    always_comb begin
        next_state   = state;
        pixel_ready  = 1'b0;
        start_t_grad = 1'b0;
        case (state)
            LOAD: begin
                pixel_ready = 1'b1;
                if (pixel_valid && !clear && idx == 4'd8) next_state = DONE;
            end
            DONE: begin
                start_t_grad = 1'b1;
                if (grad_ready) next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    // clear wins over a pixel presented in the same cycle
    assign take = pixel_valid && pixel_ready && !clear;
    assign last = (idx == 4'd8);

    assign pix  = $signed({3'b000, pixel_in});
    assign pix2 = $signed({2'b00, pixel_in, 1'b0});

    always_comb begin
        dx = '0;
        dy = '0;
        case (idx)
            4'd0: begin dx = -pix;  dy = -pix;  end
            4'd1: begin             dy = -pix2; end
            4'd2: begin dx = pix;   dy = -pix;  end
            4'd3: begin dx = -pix2;             end
            4'd5: begin dx = pix2;              end
            4'd6: begin dx = -pix;  dy = pix;   end
            4'd7: begin             dy = pix2;  end
            4'd8: begin dx = pix;   dy = pix;   end
            default: begin dx = '0; dy = '0;    end
        endcase
    end

    assign sum_x = acc_x + dx;
    assign sum_y = acc_y + dy;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx   <= '0;
            acc_x <= '0;
            acc_y <= '0;
            gx    <= '0;
            gy    <= '0;
        end else if (state == LOAD) begin
            if (clear) begin
                idx   <= '0;
                acc_x <= '0;
                acc_y <= '0;
            end else if (take) begin
                if (last) begin
                    gx    <= sum_x;
                    gy    <= sum_y;
                    idx   <= '0;
                    acc_x <= '0;
                    acc_y <= '0;
                end else begin
                    idx   <= idx + 4'd1;
                    acc_x <= sum_x;
                    acc_y <= sum_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient_gen.sv
// Randomized self-checking bench for sobel_gradient_gen against a plain
// weighted-sum model of the Sobel kernels.
module tb_sobel_gradient_gen;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        clear;
    logic [10:0] gx, gy;
    logic        start_t_grad;
    logic        grad_ready;

    int n_cmp = 0;
    int n_err = 0;

    localparam int WX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int WY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    sobel_gradient_gen dut (
        .clk(clk), .n_rst(n_rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .clear(clear), .gx(gx), .gy(gy),
        .start_t_grad(start_t_grad), .grad_ready(grad_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ref_gx(input logic [7:0] w [9]);
        int s = 0;
        for (int i = 0; i < 9; i++) s += WX[i] * int'(w[i]);
        return 11'(s);
    endfunction

    function automatic logic [10:0] ref_gy(input logic [7:0] w [9]);
        int s = 0;
        for (int i = 0; i < 9; i++) s += WY[i] * int'(w[i]);
        return 11'(s);
    endfunction

    // Drives one pixel for one cycle; caller is positioned at a falling edge.
    task automatic send_pixel(input logic [7:0] p);
        pixel_valid = 1'b1;
        pixel_in    = p;
        @(negedge clk);
        pixel_valid = 1'b0;
        pixel_in    = 8'($urandom);
    endtask

    task automatic send_window(input logic [7:0] w [9], input bit gaps);
        for (int i = 0; i < 9; i++) begin
            if (gaps && (i % 2 == 1)) @(negedge clk);
            send_pixel(w[i]);
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b1; pixel_valid = 1'b0; pixel_in = '0; clear = 1'b0; grad_ready = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        n_cmp++; if (gx !== 11'd0 || gy !== 11'd0) begin n_err++; $display("FAIL reset_grad gx=%h gy=%h want 0 0", gx, gy); end
        n_cmp++; if (start_t_grad !== 1'b0) begin n_err++; $display("FAIL reset_start got %b want 0", start_t_grad); end
        n_cmp++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", pixel_ready); end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_flat;
        logic [7:0] w [9];
        int hi = 0;
        for (int i = 0; i < 9; i++) w[i] = 8'd100;
        grad_ready = 1'b1;
        send_window(w, 1'b0);
        n_cmp++; if (start_t_grad !== 1'b1) begin n_err++; $display("FAIL flat_latency start=%b want 1", start_t_grad); end
        n_cmp++; if (gx !== 11'd0 || gy !== 11'd0) begin n_err++; $display("FAIL flat_grad gx=%h gy=%h want 0 0", gx, gy); end
        for (int c = 0; c < 5; c++) begin
            if (start_t_grad === 1'b1) hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi != 1) begin n_err++; $display("FAIL flat_start_len got %0d want 1", hi); end
    endtask

    task automatic test_right_edge;
        logic [7:0] w [9] = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
        send_window(w, 1'b0);
        n_cmp++; if (start_t_grad !== 1'b1 || gx !== 11'h3FC || gy !== 11'h000) begin
            n_err++; $display("FAIL right_edge start=%b gx=%h gy=%h want 1 3fc 000", start_t_grad, gx, gy); end
        @(negedge clk);
    endtask

    task automatic test_top_edge;
        logic [7:0] w [9] = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_window(w, 1'b0);
        n_cmp++; if (start_t_grad !== 1'b1 || gx !== 11'h000 || gy !== 11'h404) begin
            n_err++; $display("FAIL top_edge start=%b gx=%h gy=%h want 1 000 404", start_t_grad, gx, gy); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] w [9];
        logic [7:0] r [9] = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
        logic [10:0] ex, ey;
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom);
        ex = ref_gx(w); ey = ref_gy(w);
        grad_ready = 1'b0;
        send_window(w, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if (start_t_grad !== 1'b1 || pixel_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold_c%0d start=%b ready=%b want 1 0", c, start_t_grad, pixel_ready); end
            n_cmp++; if (gx !== ex || gy !== ey) begin
                n_err++; $display("FAIL bp_stable_c%0d gx=%h gy=%h want %h %h", c, gx, gy, ex, ey); end
            pixel_valid = 1'b1;
            pixel_in    = 8'($urandom);
            clear       = (c == 2);
            grad_ready  = (c == 4);
            @(negedge clk);
        end
        pixel_valid = 1'b0; clear = 1'b0;
        n_cmp++; if (start_t_grad !== 1'b0 || gx !== ex || gy !== ey) begin
            n_err++; $display("FAIL bp_release start=%b gx=%h gy=%h want 0 %h %h", start_t_grad, gx, gy, ex, ey); end
        send_window(r, 1'b0);
        n_cmp++; if (gx !== 11'h3FC || gy !== 11'h000) begin
            n_err++; $display("FAIL bp_next_window gx=%h gy=%h want 3fc 000", gx, gy); end
        @(negedge clk);
    endtask

    task automatic test_abort_reset;
        logic [7:0] r [9] = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
        for (int i = 0; i < 5; i++) send_pixel(8'($urandom_range(50, 255)));
        #2 n_rst = 1'b0;
        #1;
        n_cmp++; if (gx !== 11'd0 || gy !== 11'd0 || start_t_grad !== 1'b0 || pixel_ready !== 1'b1) begin
            n_err++; $display("FAIL abort_reset_async gx=%h gy=%h start=%b ready=%b want 0 0 0 1", gx, gy, start_t_grad, pixel_ready); end
        @(negedge clk);
        n_rst = 1'b1;
        send_window(r, 1'b0);
        n_cmp++; if (start_t_grad !== 1'b1 || gx !== 11'h3FC || gy !== 11'h000) begin
            n_err++; $display("FAIL abort_reset_window start=%b gx=%h gy=%h want 1 3fc 000", start_t_grad, gx, gy); end
        @(negedge clk);
    endtask

    task automatic test_abort_clear;
        logic [7:0] t [9] = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 5; i++) send_pixel(8'($urandom_range(50, 255)));
        clear = 1'b1; pixel_valid = 1'b1; pixel_in = 8'd255;
        @(negedge clk);
        clear = 1'b0; pixel_valid = 1'b0;
        n_cmp++; if (start_t_grad !== 1'b0 || gx !== 11'h3FC || gy !== 11'h000) begin
            n_err++; $display("FAIL abort_clear_hold start=%b gx=%h gy=%h want 0 3fc 000", start_t_grad, gx, gy); end
        send_window(t, 1'b0);
        n_cmp++; if (start_t_grad !== 1'b1 || gx !== 11'h000 || gy !== 11'h404) begin
            n_err++; $display("FAIL abort_clear_window start=%b gx=%h gy=%h want 1 000 404", start_t_grad, gx, gy); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] w [9];
        logic [10:0] ex, ey;
        logic [10:0] px = 11'h000, py = 11'h404;
        int d;
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 9; i++) w[i] = (n < 2) ? 8'((n == 0) ? ((WX[i] > 0) ? 255 : 0) : ((WY[i] < 0) ? 255 : 0))
                                                       : 8'($urandom);
            ex = ref_gx(w); ey = ref_gy(w);
            d = $urandom_range(0, 3);
            grad_ready = (d == 0);
            n_cmp++; if (gx !== px || gy !== py) begin
                n_err++; $display("FAIL rand%0d_hold gx=%h gy=%h want %h %h", n, gx, gy, px, py); end
            send_window(w, 1'($urandom));
            n_cmp++; if (start_t_grad !== 1'b1 || gx !== ex || gy !== ey) begin
                n_err++; $display("FAIL rand%0d_result start=%b gx=%h gy=%h want 1 %h %h", n, start_t_grad, gx, gy, ex, ey); end
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                n_cmp++; if (start_t_grad !== 1'b1) begin
                    n_err++; $display("FAIL rand%0d_wait start=%b want 1", n, start_t_grad); end
            end
            grad_ready = 1'b1;
            @(negedge clk);
            n_cmp++; if (start_t_grad !== 1'b0) begin
                n_err++; $display("FAIL rand%0d_release start=%b want 0", n, start_t_grad); end
            px = ex; py = ey;
        end
    endtask

    initial begin
        test_reset;
        test_flat;
        test_right_edge;
        test_top_edge;
        test_back_to_back;
        test_abort_reset;
        test_abort_clear;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_gradient_gen.md
SOBEL_GRADIENT_GEN -- requirements
Module: sobel_gradient_gen

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 pixel_in  input  8  unsigned pixel of the current 3x3 window, raster order p0..p8.
REQ-005 pixel_valid  input  1  pixel_in is valid this cycle.
REQ-006 pixel_ready  output  1  block accepts a pixel this cycle.
REQ-007 clear  input  1  synchronous abort of the window being loaded.
REQ-008 gx  output  11  signed two's-complement horizontal gradient; drives total_gradient.gx.
REQ-009 gy  output  11  signed two's-complement vertical gradient; drives total_gradient.gy.
REQ-010 start_t_grad  output  1  gx/gy result valid; drives total_gradient.start_t_grad.
REQ-011 grad_ready  input  1  downstream consumed the result; tie high if the consumer is combinational.

Function
REQ-012 A pixel SHALL be accepted on a rising edge only when pixel_valid=1 and pixel_ready=1.
REQ-013 The FSM SHALL have two states: LOAD (pixel_ready=1, start_t_grad=0) and DONE (pixel_ready=0, start_t_grad=1).
REQ-014 In LOAD, a 4-bit index SHALL count accepted pixels 0..8; the index is not advanced when no pixel is accepted.
REQ-015 Each accepted pixel SHALL be added, with its kernel weight, into two 11-bit signed accumulators in the same edge.
- gx weights p0..p8: -1, 0, +1, -2, 0, +2, -1, 0, +1.
- gy weights p0..p8: -1, -2, -1, 0, 0, 0, +1, +2, +1.
REQ-016 Weight x2 SHALL be implemented as a shift; the 8-bit pixel is zero-extended before the signed add.
REQ-017 Result range SHALL be -1020..+1020 and SHALL never overflow 11 bits; no saturation in this block.
REQ-018 On acceptance of p8, the following SHALL happen on the same edge:
- gx and gy register the final accumulator sums;
- the FSM enters DONE;
- the index and accumulators clear to 0.
REQ-019 Latency: start_t_grad SHALL be high in the first cycle after the edge that accepts p8.
REQ-020 In DONE, start_t_grad SHALL stay high and gx/gy SHALL stay stable until an edge with grad_ready=1; that edge returns the FSM to LOAD.
REQ-021 With grad_ready tied high, DONE SHALL last exactly one cycle, giving a throughput of one result per 10 cycles.
REQ-022 gx/gy SHALL hold the last result in LOAD; they update only per REQ-018.
REQ-023 clear=1 in LOAD SHALL zero the index and accumulators and ignore that cycle's pixel; gx/gy are unchanged.
REQ-024 clear=1 in DONE SHALL be ignored.
REQ-025 pixel_valid in DONE SHALL have no effect; no pixel is lost because pixel_ready=0 in DONE.

Reset
REQ-026 n_rst=0 SHALL immediately, independent of clk, force:
- state LOAD, index 0, accumulators 0;
- gx=0, gy=0, start_t_grad=0, pixel_ready=1.
REQ-027 Reset asserted mid-window SHALL discard the partial window; the next 9 accepted pixels form a fresh window.
REQ-028 After n_rst deasserts, the first rising edge SHALL operate normally.

Verification
REQ-029 Reset: assert n_rst=0 -> gx=0, gy=0, start_t_grad=0, pixel_ready=1 without a clock edge.
REQ-030 Flat window: 9 x 100, valid every cycle, grad_ready=1 -> gx=0, gy=0, start_t_grad high for exactly 1 cycle, 1 cycle after p8.
REQ-031 Right column edge: 0,0,255,0,0,255,0,0,255 -> gx=1020 (11'h3FC), gy=0.
REQ-032 Top row edge: 255,255,255,0,0,0,0,0,0 -> gx=0, gy=-1020 (11'h404).
REQ-033 Backpressure and gaps:
- stimulus: pixel_valid toggles 1/0, and grad_ready=0 for 3 cycles after the result;
- required: start_t_grad high 4 cycles, pixel_ready=0, gx/gy stable throughout, release on the grad_ready edge.
REQ-034 Abort:
- stimulus: n_rst pulse after 5 pixels (separately: clear after 5 pixels), then the right-column window;
- required: gx=1020, gy=0, with no residue from the aborted pixels.
